// File: rtl/usb_pkg.sv
// Shared USB link-layer constants: bag-type codes (common with usb_tx/usb_rx),
// usb_arq_ctrl FSM state encodings and the default bag-type width.
package usb_pkg;

    localparam int BTW_DEF = 4;

    localparam logic [3:0] BAG_INIT  = 4'h0;
    localparam logic [3:0] BAG_ACK   = 4'h1;
    localparam logic [3:0] BAG_NAK   = 4'h2;
    localparam logic [3:0] BAG_RLY   = 4'h3;
    localparam logic [3:0] BAG_DLINK = 4'h8;
    localparam logic [3:0] BAG_DTYPE = 4'h9;
    localparam logic [3:0] BAG_DTEMP = 4'hA;
    localparam logic [3:0] BAG_DATA0 = 4'hD;
    localparam logic [3:0] BAG_DATA1 = 4'hE;
    localparam logic [3:0] BAG_ERROR = 4'hF;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_WAIT      = 4'd1;
    localparam logic [3:0] ST_SEND_PREP = 4'd2;
    localparam logic [3:0] ST_SEND_DATA = 4'd3;
    localparam logic [3:0] ST_RANS_WAIT = 4'd4;
    localparam logic [3:0] ST_RANS_TOUT = 4'd5;
    localparam logic [3:0] ST_RANS_TAKE = 4'd6;
    localparam logic [3:0] ST_RANS_DONE = 4'd7;
    localparam logic [3:0] ST_RANS_RPLY = 4'd8;
    localparam logic [3:0] ST_SEND_DONE = 4'd9;
    localparam logic [3:0] ST_SEND_FAIL = 4'd10;
    localparam logic [3:0] ST_READ_PREP = 4'd11;
    localparam logic [3:0] ST_READ_DATA = 4'd12;
    localparam logic [3:0] ST_WANS_PREP = 4'd13;
    localparam logic [3:0] ST_WANS_DONE = 4'd14;
    localparam logic [3:0] ST_READ_DONE = 4'd15;

endpackage

// File: rtl/usb_arq_ctrl_if.sv
// Handshake bundle between usb_arq_ctrl and its neighbours (user, usb_tx, usb_rx).
// slave = the controller's view, master = the surrounding logic's view.
interface usb_arq_ctrl_if #(
    parameter int BTW    = 4,
    parameter int RAM_AW = 12
);
    logic              fs_send;
    logic              fd_send;
    logic              ff_send;
    logic [BTW-1:0]    send_btype;
    logic              fs_read;
    logic              fd_read;
    logic [BTW-1:0]    read_btype;
    logic              fs_tx;
    logic              fd_tx;
    logic [BTW-1:0]    tx_btype;
    logic              fs_rx;
    logic              fd_rx;
    logic [BTW-1:0]    rx_btype;
    logic [3:0]        data_idx;
    logic [RAM_AW-1:0] rx_ram_init;
    logic [7:0]        retry_cnt;

    modport slave (
        input  fs_send, send_btype, fd_read, fd_tx, fs_rx, rx_btype, data_idx,
        output fd_send, ff_send, fs_read, read_btype, fs_tx, tx_btype, fd_rx,
               rx_ram_init, retry_cnt
    );

    modport master (
        output fs_send, send_btype, fd_read, fd_tx, fs_rx, rx_btype, data_idx,
        input  fd_send, ff_send, fs_read, read_btype, fs_tx, tx_btype, fd_rx,
               rx_ram_init, retry_cnt
    );
endinterface

// File: rtl/usb_ram_base.sv
// Combinational ADC slot base address: idx*RAM_STRIDE truncated to RAM_AW,
// with a flag telling whether idx names one of the NCH slots.
module usb_ram_base #(
    parameter int NCH        = 6,
    parameter int RAM_AW     = 12,
    parameter int RAM_STRIDE = 'h240
) (
    input  logic [3:0]        idx_i,
    output logic [RAM_AW-1:0] addr_o,
    output logic              valid_o
);
    assign addr_o  = RAM_AW'(32'(idx_i) * 32'(RAM_STRIDE));
    assign valid_o = 32'(idx_i) < 32'(NCH);
endmodule

// File: rtl/usb_arq_ctrl.sv
// USB link-layer control: stop-and-wait ARQ send side, ACK/NAK/RLY receive side
// with DATA0/DATA1 duplicate suppression. Define USB_ARQ_STAT_EN for stat counters.
module usb_arq_ctrl
    import usb_pkg::*;
#(
    parameter int TIMEOUT    = 128,
    parameter int NUMOUT     = 16,
    parameter int NCH        = 6,
    parameter int RAM_AW     = 12,
    parameter int RAM_STRIDE = 'h240,
    parameter int RAM_INIT   = 'hF00,
    parameter int BTW        = BTW_DEF
) (
    input logic clk,
    input logic rst_n,
    usb_arq_ctrl_if.slave bus
`ifdef USB_ARQ_STAT_EN
    ,
    output logic [15:0] stat_tout,
    output logic [15:0] stat_nak,
    output logic [15:0] stat_dup
`endif
);
    localparam int         TW       = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
    localparam logic [7:0] NUM_LAST = 8'(NUMOUT - 1);

    logic [3:0]        state_q, state_d, goto_q, goto_d;
    logic [TW-1:0]     time_cnt_q, time_cnt_d;
    logic [7:0]        num_cnt_q, num_cnt_d, num_inc, retry_q, retry_d;
    logic [BTW-1:0]    tx_btype_q, tx_btype_d, read_btype_q, read_btype_d;
    logic [BTW-1:0]    last_data_q, last_data_d;
    logic              dup_vld_q, dup_vld_d, skip_read_q, skip_read_d;
    logic              is_dup, rx_is_data, rd_is_data;
    logic [RAM_AW-1:0] ram_init_q, base_addr;
    logic              base_vld;

    usb_ram_base #(.NCH(NCH), .RAM_AW(RAM_AW), .RAM_STRIDE(RAM_STRIDE)) u_ram_base (
        .idx_i   (bus.data_idx),
        .addr_o  (base_addr),
        .valid_o (base_vld)
    );

    assign num_inc    = (num_cnt_q == 8'hFF) ? num_cnt_q : num_cnt_q + 8'd1;
    assign rx_is_data = (bus.rx_btype == BTW'(BAG_DATA0)) || (bus.rx_btype == BTW'(BAG_DATA1));
    assign rd_is_data = (read_btype_q == BTW'(BAG_DATA0)) || (read_btype_q == BTW'(BAG_DATA1));
    assign is_dup     = rx_is_data && dup_vld_q && (bus.rx_btype == last_data_q);

    // NOTE: every next-state variable gets a default first, so no path through the case infers a latch.
    always_comb begin
        state_d      = state_q;
        goto_d       = goto_q;
        time_cnt_d   = time_cnt_q;
        num_cnt_d    = num_cnt_q;
        tx_btype_d   = tx_btype_q;
        read_btype_d = read_btype_q;
        skip_read_d  = skip_read_q;
        last_data_d  = last_data_q;
        dup_vld_d    = dup_vld_q;
        retry_d      = retry_q;
        case (state_q)
            ST_IDLE: state_d = ST_WAIT;
            ST_WAIT: begin
                time_cnt_d = '0;
                num_cnt_d  = '0;
                if (bus.fs_send)    state_d = ST_SEND_PREP;
                else if (bus.fs_rx) state_d = ST_READ_PREP;
            end
            ST_SEND_PREP: begin
                tx_btype_d = bus.send_btype;
                state_d    = ST_SEND_DATA;
            end
            ST_SEND_DATA: begin
                time_cnt_d = '0;
                if (bus.fd_tx) state_d = ST_RANS_WAIT;
            end
            ST_RANS_WAIT: begin
                time_cnt_d = time_cnt_q + 1'b1;
                if (time_cnt_q >= TW'(TIMEOUT - 1)) state_d = ST_RANS_TOUT;
                else if (bus.fs_rx)                 state_d = ST_RANS_TAKE;
            end
            ST_RANS_TOUT: begin
                num_cnt_d = num_inc;
                state_d   = (num_cnt_q >= NUM_LAST) ? ST_SEND_FAIL : ST_SEND_DATA;
            end
            ST_RANS_TAKE: begin
                num_cnt_d  = num_inc;
                tx_btype_d = BTW'(BAG_RLY);
                if (bus.rx_btype == BTW'(BAG_ACK))
                    goto_d = ST_SEND_DONE;
                else if (bus.rx_btype == BTW'(BAG_NAK) && num_cnt_q >= NUM_LAST)
                    goto_d = ST_SEND_FAIL;
                else
                    goto_d = ST_SEND_DATA;
                state_d = ST_RANS_DONE;
            end
            ST_RANS_DONE: if (!bus.fs_rx) state_d = ST_RANS_RPLY;
            ST_RANS_RPLY: begin
                if (bus.fd_tx) begin
                    state_d = goto_q;
                    if (goto_q == ST_SEND_DATA) tx_btype_d = bus.send_btype;
                end
            end
            ST_SEND_DONE, ST_SEND_FAIL: if (!bus.fs_send) state_d = ST_WAIT;
            ST_READ_PREP: state_d = ST_READ_DATA;
            ST_READ_DATA: if (!bus.fs_rx) state_d = ST_WANS_PREP;
            ST_WANS_PREP: begin
                read_btype_d = bus.rx_btype;
                skip_read_d  = 1'b0;
                state_d      = ST_WANS_DONE;
                case (bus.rx_btype)
                    BTW'(BAG_ERROR): tx_btype_d = BTW'(BAG_NAK);
                    BTW'(BAG_ACK), BTW'(BAG_NAK): begin
                        tx_btype_d  = BTW'(BAG_RLY);
                        skip_read_d = 1'b1;
                    end
                    BTW'(BAG_DLINK), BTW'(BAG_DTYPE), BTW'(BAG_DTEMP),
                    BTW'(BAG_DATA0), BTW'(BAG_DATA1): begin
                        tx_btype_d  = BTW'(BAG_ACK);
                        skip_read_d = is_dup;
                    end
                    default: state_d = ST_WAIT;
                endcase
            end
            ST_WANS_DONE: begin
                if (bus.fd_tx) begin
                    state_d = skip_read_q ? ST_WAIT : ST_READ_DONE;
                    if (!skip_read_q && rd_is_data) begin
                        last_data_d = read_btype_q;
                        dup_vld_d   = 1'b1;
                    end
                end
            end
            ST_READ_DONE: if (bus.fd_read) state_d = ST_WAIT;
            default: state_d = ST_IDLE;
        endcase
        // The attempt count is frozen with the already-incremented counter on entry.
        if ((state_d == ST_SEND_DONE || state_d == ST_SEND_FAIL) && state_d != state_q)
            retry_d = num_cnt_d;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            goto_q       <= ST_IDLE;
            time_cnt_q   <= '0;
            num_cnt_q    <= '0;
            tx_btype_q   <= BTW'(BAG_INIT);
            read_btype_q <= BTW'(BAG_INIT);
            last_data_q  <= BTW'(BAG_INIT);
            dup_vld_q    <= 1'b0;
            skip_read_q  <= 1'b0;
            retry_q      <= '0;
            ram_init_q   <= RAM_AW'(RAM_INIT);
        end else begin
            state_q      <= state_d;
            goto_q       <= goto_d;
            time_cnt_q   <= time_cnt_d;
            num_cnt_q    <= num_cnt_d;
            tx_btype_q   <= tx_btype_d;
            read_btype_q <= read_btype_d;
            last_data_q  <= last_data_d;
            dup_vld_q    <= dup_vld_d;
            skip_read_q  <= skip_read_d;
            retry_q      <= retry_d;
            if (base_vld) ram_init_q <= base_addr;
        end
    end

    // Handshake outputs decode straight from state so an async reset drops them at once.
    assign bus.fs_tx       = (state_q == ST_SEND_DATA) || (state_q == ST_RANS_RPLY) ||
                             (state_q == ST_WANS_DONE);
    assign bus.fd_rx       = (state_q == ST_RANS_DONE) || (state_q == ST_READ_DATA);
    assign bus.fd_send     = (state_q == ST_SEND_DONE) || (state_q == ST_SEND_FAIL);
    assign bus.ff_send     = (state_q == ST_SEND_FAIL);
    assign bus.fs_read     = (state_q == ST_READ_DONE);
    assign bus.tx_btype    = tx_btype_q;
    assign bus.read_btype  = read_btype_q;
    assign bus.rx_ram_init = ram_init_q;
    assign bus.retry_cnt   = retry_q;

`ifdef USB_ARQ_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_tout <= '0;
            stat_nak  <= '0;
            stat_dup  <= '0;
        end else begin
            if (state_d == ST_RANS_TOUT && state_q != ST_RANS_TOUT && stat_tout != 16'hFFFF)
                stat_tout <= stat_tout + 16'd1;
            if (state_q == ST_RANS_TAKE && bus.rx_btype == BTW'(BAG_NAK) && stat_nak != 16'hFFFF)
                stat_nak <= stat_nak + 16'd1;
            if (state_q == ST_WANS_PREP && is_dup && stat_dup != 16'hFFFF)
                stat_dup <= stat_dup + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_usb_arq_ctrl.sv
// Directed bench for usb_arq_ctrl (TIMEOUT=8, NUMOUT=3, NCH=6): send, timeout,
// NAK retry, receive with duplicate drop, reply selection, slot base and reset.
module tb_usb_arq_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    usb_arq_ctrl_if #(.BTW(4), .RAM_AW(12)) bus ();

    usb_arq_ctrl #(
        .TIMEOUT(8), .NUMOUT(3), .NCH(6), .RAM_AW(12),
        .RAM_STRIDE('h240), .RAM_INIT('hF00), .BTW(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_fs_tx(input string tag);
        int n = 0;
        while (!bus.fs_tx && n < 200) begin tick(1); n++; end
        check({tag, " fs_tx seen"}, 32'(bus.fs_tx), 32'd1);
    endtask

    task automatic wait_fd_send(input string tag);
        int n = 0;
        while (!bus.fd_send && n < 200) begin tick(1); n++; end
        check({tag, " fd_send seen"}, 32'(bus.fd_send), 32'd1);
    endtask

    task automatic tx_done();
        bus.fd_tx = 1'b1;
        tick(1);
        bus.fd_tx = 1'b0;
    endtask

    task automatic rx_pkt(input string tag, input logic [3:0] b);
        int n = 0;
        bus.rx_btype = b;
        bus.fs_rx    = 1'b1;
        while (!bus.fd_rx && n < 200) begin tick(1); n++; end
        check({tag, " fd_rx seen"}, 32'(bus.fd_rx), 32'd1);
        bus.fs_rx = 1'b0;
        tick(1);
    endtask

    task automatic read_ack();
        bus.fd_read = 1'b1;
        tick(1);
        bus.fd_read = 1'b0;
    endtask

    initial begin
        logic [11:0] base_exp [8];
        int          n;
        int          tx_seen;
        base_exp = '{12'h000, 12'h240, 12'h480, 12'h6C0, 12'h900, 12'hB40, 12'hB40, 12'hB40};

        rst_n          = 1'b0;
        bus.fs_send    = 1'b0;
        bus.send_btype = 4'h0;
        bus.fd_read    = 1'b0;
        bus.fd_tx      = 1'b0;
        bus.fs_rx      = 1'b0;
        bus.rx_btype   = 4'h0;
        bus.data_idx   = 4'hF;
        tick(3);
        check("rst fs_tx",       32'(bus.fs_tx),       32'd0);
        check("rst fd_rx",       32'(bus.fd_rx),       32'd0);
        check("rst fd_send",     32'(bus.fd_send),     32'd0);
        check("rst fs_read",     32'(bus.fs_read),     32'd0);
        check("rst tx_btype",    32'(bus.tx_btype),    32'h0);
        check("rst read_btype",  32'(bus.read_btype),  32'h0);
        check("rst retry_cnt",   32'(bus.retry_cnt),   32'd0);
        check("rst rx_ram_init", 32'(bus.rx_ram_init), 32'hF00);
        rst_n = 1'b1;
        tick(2);
        check("idx15 holds init", 32'(bus.rx_ram_init), 32'hF00);

        // Clean send: DLINK, ACK reply inside the timeout window.
        bus.send_btype = 4'h8;
        bus.fs_send    = 1'b1;
        wait_fs_tx("clean data");
        check("clean tx_btype", 32'(bus.tx_btype), 32'h8);
        tick(5);
        tx_done();
        tick(3);
        rx_pkt("clean ack", 4'h1);
        wait_fs_tx("clean rly");
        check("clean rly type", 32'(bus.tx_btype), 32'h3);
        tx_done();
        wait_fd_send("clean");
        check("clean ff_send", 32'(bus.ff_send),   32'd0);
        check("clean retry",   32'(bus.retry_cnt), 32'd1);
        bus.fs_send = 1'b0;
        tick(1);
        check("clean release", 32'(bus.fd_send), 32'd0);

        // Timeout: three attempts, each followed by 8 RANS_WAIT cycles plus RANS_TOUT.
        bus.send_btype = 4'h9;
        bus.fs_send    = 1'b1;
        for (int a = 0; a < 3; a++) begin
            wait_fs_tx("tout data");
            check("tout tx_btype", 32'(bus.tx_btype), 32'h9);
            tx_done();
            n = 0;
            while (!bus.fs_tx && !bus.fd_send && n < 100) begin tick(1); n++; end
            check("tout gap", 32'(n), 32'd9);
        end
        check("tout fd_send", 32'(bus.fd_send),   32'd1);
        check("tout ff_send", 32'(bus.ff_send),   32'd1);
        check("tout retry",   32'(bus.retry_cnt), 32'd3);
        bus.fs_send = 1'b0;
        tick(1);
        check("tout release", 32'(bus.ff_send), 32'd0);

        // NAK then ACK.
        bus.send_btype = 4'hA;
        bus.fs_send    = 1'b1;
        wait_fs_tx("nak data1");
        tx_done();
        tick(2);
        rx_pkt("nak nak", 4'h2);
        wait_fs_tx("nak rly1");
        check("nak rly1 type", 32'(bus.tx_btype), 32'h3);
        tx_done();
        wait_fs_tx("nak data2");
        check("nak resend type", 32'(bus.tx_btype), 32'hA);
        tx_done();
        tick(2);
        rx_pkt("nak ack", 4'h1);
        wait_fs_tx("nak rly2");
        check("nak rly2 type", 32'(bus.tx_btype), 32'h3);
        tx_done();
        wait_fd_send("nak");
        check("nak ff_send", 32'(bus.ff_send),   32'd0);
        check("nak retry",   32'(bus.retry_cnt), 32'd2);
        bus.fs_send = 1'b0;
        tick(1);

        // DATA0, duplicate DATA0, then DATA1.
        rx_pkt("d0", 4'hD);
        wait_fs_tx("d0 ack");
        check("d0 reply", 32'(bus.tx_btype), 32'h1);
        tx_done();
        check("d0 fs_read",    32'(bus.fs_read),    32'd1);
        check("d0 read_btype", 32'(bus.read_btype), 32'hD);
        read_ack();
        check("d0 consumed", 32'(bus.fs_read), 32'd0);

        rx_pkt("dup", 4'hD);
        wait_fs_tx("dup ack");
        check("dup reply", 32'(bus.tx_btype), 32'h1);
        tx_done();
        check("dup no read", 32'(bus.fs_read), 32'd0);
        tick(2);
        check("dup still no read", 32'(bus.fs_read), 32'd0);

        rx_pkt("d1", 4'hE);
        wait_fs_tx("d1 ack");
        check("d1 reply", 32'(bus.tx_btype), 32'h1);
        tx_done();
        check("d1 fs_read",    32'(bus.fs_read),    32'd1);
        check("d1 read_btype", 32'(bus.read_btype), 32'hE);
        read_ack();

        // ERROR gets NAK and is delivered; type 4 is dropped silently.
        rx_pkt("err", 4'hF);
        wait_fs_tx("err nak");
        check("err reply", 32'(bus.tx_btype), 32'h2);
        tx_done();
        check("err fs_read",    32'(bus.fs_read),    32'd1);
        check("err read_btype", 32'(bus.read_btype), 32'hF);
        read_ack();

        rx_pkt("t4", 4'h4);
        tx_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.fs_tx || bus.fs_read) tx_seen++;
            tick(1);
        end
        check("t4 silent", 32'(tx_seen), 32'd0);

        // Slot base addresses, one-cycle latency, hold for invalid indexes.
        for (int i = 0; i < 8; i++) begin
            bus.data_idx = 4'(i);
            tick(1);
            check($sformatf("ram_init idx%0d", i), 32'(bus.rx_ram_init), 32'(base_exp[i]));
        end

        // Reset asserted while SEND_DATA is driving fs_tx.
        bus.send_btype = 4'h8;
        bus.fs_send    = 1'b1;
        wait_fs_tx("rst data");
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst fs_tx",       32'(bus.fs_tx),       32'd0);
        check("midrst tx_btype",    32'(bus.tx_btype),    32'h0);
        check("midrst rx_ram_init", 32'(bus.rx_ram_init), 32'hF00);
        bus.fs_send = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(2);
        check("postrst fd_send",     32'(bus.fd_send),     32'd0);
        check("postrst rx_ram_init", 32'(bus.rx_ram_init), 32'hF00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
